uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that sits directly upstream of the board TX pin. Producers push bytes through a write strobe and never wait on bit timing. The block queues them in a FIFO and serializes them back-to-back at DELAY_FRAMES clock cycles per bit. It replaces the hard-coded message-memory transmit path, so any logic, including the UART receive path, can emit arbitrary byte streams.

---
 rtl/uart_tx_fifo_if.sv | 24 ++
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and FIFO status for the buffered UART transmitter.
// master drives pushes; slave is the transmitter itself.
interface uart_tx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);

  logic            wr_en;
  logic [7:0]      wr_data;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO feeding a bit serializer
// that sends queued bytes back-to-back at DELAY_FRAMES clocks per bit.
module uart_tx_fifo #(
  parameter int unsigned DELAY_FRAMES = 234,
  parameter int unsigned FIFO_DEPTH   = 16,
  localparam int unsigned ADDR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus,
  output logic           busy_o,
  output logic           uart_tx_o
);

  localparam int unsigned CycW = (DELAY_FRAMES > 2) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CycW-1:0] CycLast  = CycW'(DELAY_FRAMES - 1);
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;

  state_e            state_q;
  logic [CycW-1:0]   cyc_q;
  logic [2:0]        bit_q;
  logic [2:0]        bit_nxt;
  logic [7:0]        shift_q;
  logic              tx_q;

  logic full, empty, push, pop, cyc_last;

  // Status is derived from the registered count only, so a push while full is
  // dropped even when a pop happens on the same edge.
  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign push     = bus.wr_en && !full;
  assign cyc_last = (cyc_q == CycLast);
  assign pop      = !empty && ((state_q == StIdle) || ((state_q == StStop) && cyc_last));
  assign bit_nxt  = bit_q + 3'd1;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= bus.wr_en && full;
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q <= StStart;
            shift_q <= mem_q[rd_ptr_q];
            bit_q   <= '0;
            cyc_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        StStart: begin
          if (cyc_last) begin
            cyc_q   <= '0;
            state_q <= StData;
            tx_q    <= shift_q[0];
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StData: begin
          if (cyc_last) begin
            cyc_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_nxt;
              tx_q  <= shift_q[bit_nxt];
            end
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        StStop: begin
          if (cyc_last) begin
            cyc_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              state_q <= StStart;
              shift_q <= mem_q[rd_ptr_q];
              bit_q   <= '0;
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign busy_o       = (state_q != StIdle);
  assign uart_tx_o    = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-plus-frame-schedule reference model predicts
// every output each cycle while directed and random pushes are applied.
module tb_uart_tx_fifo;
  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst_n;
  logic busy;
  logic uart_tx;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .DELAY_FRAMES(D),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy_o   (busy),
    .uart_tx_o(uart_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: queued bytes, plus the start edge and value of the frame on the line.
  logic [7:0] q[$];
  bit         inflight;
  int         fs;
  logic [7:0] cur;
  int         k;
  bit         exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_line();
    int b;
    if (!inflight) return 1'b1;
    b = (k - fs) / int'(D);
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  function automatic bit frame_end_next();
    return inflight && (k + 1 == fs + 10 * int'(D));
  endfunction

  function automatic void model_edge(input logic we, input logic [7:0] wd);
    int sz;
    bit fend;
    bit pop;
    sz   = q.size();
    fend = inflight && (k == fs + 10 * int'(D));
    pop  = (sz > 0) && (!inflight || fend);
    if (fend && !pop) inflight = 1'b0;
    exp_ovf = we && (sz == int'(DEPTH));
    if (pop) begin
      cur      = q.pop_front();
      fs       = k;
      inflight = 1'b1;
    end
    if (we && sz < int'(DEPTH)) q.push_back(wd);
  endfunction

  task automatic check_all();
    check("uart_tx",  32'(uart_tx),      32'(exp_line()));
    check("busy",     32'(busy),         32'(inflight));
    check("count",    32'(bus.count),    32'(q.size()));
    check("full",     32'(bus.full),     32'(q.size() == int'(DEPTH)));
    check("empty",    32'(bus.empty),    32'(q.size() == 0));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
  endtask

  task automatic step(input logic we, input logic [7:0] wd);
    bus.wr_en   = we;
    bus.wr_data = wd;
    @(posedge clk);
    k++;
    model_edge(we, wd);
    #1;
    check_all();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_tx"},    32'(uart_tx),      32'd1);
    check({tag, "_empty"}, 32'(bus.empty),    32'd1);
    check({tag, "_count"}, 32'(bus.count),    32'd0);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_full"},  32'(bus.full),     32'd0);
    check({tag, "_ovf"},   32'(bus.overflow), 32'd0);
    q.delete();
    inflight = 1'b0;
    exp_ovf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((inflight || q.size() > 0) && n < 2000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check({tag, "_drain_bound"}, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    int n;
    rst_n       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    k           = 0;
    fs          = 0;
    cur         = 8'h00;
    inflight    = 1'b0;
    exp_ovf     = 1'b0;
    #2;
    do_reset("reset");
    repeat (3) step(1'b0, 8'h00);

    // Single byte: start bit on the edge after the push, idle again 40 cycles later.
    step(1'b1, 8'h55);
    check("single_count", 32'(bus.count), 32'd1);
    step(1'b0, 8'h00);
    check("single_start", 32'(uart_tx), 32'd0);
    check("single_cnt0",  32'(bus.count), 32'd0);
    repeat (40) step(1'b0, 8'h00);
    check("single_busy_end", 32'(busy), 32'd0);
    repeat (5) step(1'b0, 8'h00);

    // Back-to-back frames.
    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    step(1'b1, 8'h43);
    drain("b2b");

    // Overflow: 18 pushes while the first frame is in flight.
    for (int i = 0; i < 18; i++) step(1'b1, 8'($urandom));
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_full",  32'(bus.full),     32'd1);
    step(1'b0, 8'h00);
    check("ovf_one_cycle", 32'(bus.overflow), 32'd0);

    // Push while full on the very edge the stop bit ends.
    n = 0;
    while (!(frame_end_next() && q.size() == int'(DEPTH)) && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("full_pop_bound", 32'(n < 200), 32'd1);
    step(1'b1, 8'hEE);
    check("full_pop_count", 32'(bus.count),    32'd15);
    check("full_pop_ovf",   32'(bus.overflow), 32'd1);

    // Push coinciding with a pop at count 5.
    n = 0;
    while (!(frame_end_next() && q.size() == 5) && n < 2000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("cnt5_bound", 32'(n < 2000), 32'd1);
    step(1'b1, 8'h3C);
    check("cnt5_same", 32'(bus.count), 32'd5);
    drain("ovf");

    // Reset during data bit 3.
    step(1'b1, 8'hA7);
    n = 0;
    while (!(inflight && (k - fs) / int'(D) == 4) && n < 100) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("midreset_bound", 32'(n < 100), 32'd1);
    step(1'b1, 8'h99);
    do_reset("midreset");
    repeat (50) step(1'b0, 8'h00);

    // Pointer wrap: 40 bytes in bursts of 10.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 8'(b * 10 + i));
      drain("wrap");
    end
    check("wrap_empty", 32'(bus.empty), 32'd1);
    check("wrap_count", 32'(bus.count), 32'd0);

    // Random pushes.
    for (int i = 0; i < 600; i++) step($urandom_range(0, 5) == 0, 8'($urandom));
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
